// File: rtl/mem_march_bist.sv
// ============================================================================
// mem_march_bist : March C- BIST initiator for a single-port test memory
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_march_bist #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0,
  parameter int                ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ONLY = 3'd1,
    RD     = 3'd2,
    RW_CHK = 3'd3,
    RD_CHK = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [DATA_W-1:0] BG_INV   = ~BG;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        elem;
  logic              launch, check, step;
  logic              down, last_addr, mismatch;
  logic [DATA_W-1:0] expect_data, write_val;
  logic [ERR_W-1:0]  err_next;

  assign down        = (elem == 3'd3) || (elem == 3'd4);
  assign last_addr   = down ? (addr == '0) : (addr == ADDR_MAX);
  assign expect_data = ((elem == 3'd2) || (elem == 3'd4)) ? BG_INV : BG;
  assign write_val   = ((elem == 3'd1) || (elem == 3'd3)) ? BG_INV : BG;
  assign step        = (state == W_ONLY) || (state == RW_CHK) || (state == RD_CHK);
  assign mismatch    = check && (mem_read_data != expect_data);
  assign err_next    = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_W'(1) : err_count;

  // Memory-side outputs decode only from registered state and address.
  assign mem_write_en   = (state == W_ONLY) || (state == RW_CHK);
  assign mem_read_en    = (state == RD);
  assign mem_addr       = addr;
  assign mem_write_data = (state == W_ONLY) ? BG :
                          (state == RW_CHK) ? write_val : '0;
  assign busy           = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    check      = 1'b0;
    case (state)
      IDLE:    if (start) begin
                 state_next = W_ONLY;
                 launch     = 1'b1;
               end
      W_ONLY:  if (last_addr) state_next = RD;
      RD:      state_next = (elem == 3'd5) ? RD_CHK : RW_CHK;
      RW_CHK:  begin
                 check      = 1'b1;
                 state_next = RD;
               end
      RD_CHK:  begin
                 check      = 1'b1;
                 state_next = last_addr ? DONE : RD;
               end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      elem      <= '0;
      err_count <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (launch) begin
      addr      <= '0;
      elem      <= '0;
      err_count <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      if (step) begin
        // Element boundary: next element begins at its own first address.
        if (last_addr && (state != RD_CHK)) begin
          elem <= elem + 3'd1;
          addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
        end else begin
          addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
      end
      err_count <= err_next;
      if (mismatch && (err_count == '0)) begin
        fail_addr <= addr;
        fail_elem <= elem;
        fail_data <= mem_read_data;
      end
      if ((state == RD_CHK) && last_addr) begin
        done <= 1'b1;
        pass <= (err_next == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_march_bist.sv
// ============================================================================
// tb_mem_march_bist : randomized March C- bench with faulty-memory model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_march_bist;

  localparam int         DEPTH = 256;
  localparam logic [7:0] BG    = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mem_write_en, mem_read_en;
  logic [7:0] mem_addr, mem_write_data;
  logic [7:0] mem_read_data;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_addr, fail_data;
  logic [2:0] fail_elem;

  always #5 clk = ~clk;

  mem_march_bist #(.ADDR_W(8), .DATA_W(8), .BG(BG), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data)
  );

  // Fault injection: 0 none, 1 single stuck bit at one address, 2 every read A5.
  int         fmode = 0;
  logic [7:0] faddr = 8'h00;
  int         fbit  = 0;
  logic       fval  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] faulty(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (fmode == 2) r = 8'hA5;
    else if (fmode == 1 && a == faddr) r[fbit] = fval;
    return r;
  endfunction

  logic [7:0] mem [DEPTH];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= faulty(mem_addr, mem[mem_addr]);
  end

  // Expected per-cycle operation stream {we, re, addr, wdata} and run results.
  logic [17:0] exp_q[$];
  int          exp_errs;
  logic [7:0]  exp_faddr, exp_fdata;
  logic [2:0]  exp_felem;

  task automatic build_model();
    logic [7:0] m [DEPTH];
    logic [7:0] rexp, wval, a, r;
    bit         dn;
    exp_q.delete();
    exp_errs = 0; exp_faddr = 0; exp_fdata = 0; exp_felem = 0;
    for (int e = 0; e < 6; e++) begin
      dn   = (e == 3 || e == 4);
      rexp = (e == 2 || e == 4) ? ~BG : BG;
      wval = (e == 1 || e == 3) ? ~BG : BG;
      for (int k = 0; k < DEPTH; k++) begin
        a = dn ? 8'(DEPTH - 1 - k) : 8'(k);
        if (e == 0) begin
          m[a] = BG;
          exp_q.push_back({1'b1, 1'b0, a, BG});
        end else begin
          exp_q.push_back({1'b0, 1'b1, a, 8'h00});
          r = faulty(a, m[a]);
          if (r != rexp) begin
            if (exp_errs == 0) begin
              exp_faddr = a; exp_felem = 3'(e); exp_fdata = r;
            end
            exp_errs++;
          end
          if (e < 5) begin
            m[a] = wval;
            exp_q.push_back({1'b1, 1'b0, a, wval});
          end else begin
            exp_q.push_back({1'b0, 1'b0, a, 8'h00});
          end
        end
      end
    end
  endtask

  task automatic run_test(input string name, input int poke_at);
    int          cyc, tmis;
    logic [17:0] ev;
    build_model();
    foreach (mem[i]) mem[i] = 8'($urandom);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; tmis = 0;
    while (busy && cyc < 4000) begin
      if (mem_write_en && mem_read_en) tmis++;
      if (cyc < exp_q.size()) begin
        ev = exp_q[cyc];
        if (mem_write_en !== ev[17] || mem_read_en !== ev[16]) tmis++;
        else if ((ev[17] || ev[16]) && mem_addr !== ev[15:8]) tmis++;
        else if (ev[17] && mem_write_data !== ev[7:0]) tmis++;
      end else begin
        tmis++;
      end
      cyc++;
      start = (cyc == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({name, "/busy_cycles"}, cyc, 2816);
    check_eq({name, "/op_trace"}, tmis, 0);
    check_eq({name, "/done"}, done, 1);
    check_eq({name, "/pass"}, pass, (exp_errs == 0));
    check_eq({name, "/err_count"}, err_count, (exp_errs > 255) ? 255 : exp_errs);
    check_eq({name, "/fail_addr"}, fail_addr, exp_faddr);
    check_eq({name, "/fail_elem"}, fail_elem, exp_felem);
    check_eq({name, "/fail_data"}, fail_data, exp_fdata);
  endtask

  task automatic abort_run();
    int cyc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    #1 rst = 1'b0;
    #1;
    check_eq("abort/cycle", cyc, 1000);
    check_eq("abort/enables", {mem_write_en, mem_read_en}, 0);
    check_eq("abort/busy", busy, 0);
    check_eq("abort/done", done, 0);
    check_eq("abort/err_count", err_count, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check_eq("reset/busy", busy, 0);
    check_eq("reset/done_pass", {done, pass}, 0);
    check_eq("reset/enables", {mem_write_en, mem_read_en}, 0);
    check_eq("reset/err_count", err_count, 0);
    check_eq("reset/fail_info", {fail_addr, fail_elem, fail_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    fmode = 0;
    run_test("clean", 500);
    bad = 0;
    foreach (mem[i]) if (mem[i] !== BG) bad++;
    check_eq("clean/final_mem", bad, 0);

    fmode = 1; faddr = 8'h37; fbit = 2; fval = 1'b1;
    run_test("sa1_37", 0);
    check_eq("sa1_37/count_plan", err_count, 3);
    check_eq("sa1_37/addr_plan", fail_addr, 8'h37);
    check_eq("sa1_37/data_plan", fail_data, 8'h04);

    fmode = 2;
    run_test("all_a5", 0);
    check_eq("all_a5/saturate", err_count, 8'hFF);

    for (int t = 0; t < 4; t++) begin
      fmode = 1;
      faddr = 8'($urandom);
      fbit  = int'($urandom_range(0, 7));
      fval  = 1'($urandom_range(0, 1));
      run_test($sformatf("rand%0d", t), int'($urandom_range(10, 2800)));
    end

    fmode = 0;
    abort_run();
    run_test("after_abort", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
